// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program memory and its byte-stream loader.
package prog_mem_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FULL} prog_mem_state_t;
  localparam int LANE_W = 8;
endpackage

// File: rtl/prog_mem_ram.sv
// Simple dual-port word array: one write port, one registered read port with valid.
// Build option PROG_MEM_BYPASS_EN: same-address write/read returns the new word.
module prog_mem_ram
  import prog_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [DATA_W-1:0] w_rd_word;

  // Array contents survive reset so a loaded program outlives a loader abort.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

`ifdef PROG_MEM_BYPASS_EN
  assign w_rd_word = (wr_en && (wr_addr == rd_addr)) ? wr_data : r_mem[rd_addr];
`else
  assign w_rd_word = r_mem[rd_addr];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_word;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
endmodule

// File: rtl/prog_mem.sv
// Program memory with UART byte-stream loader (IDLE/LOAD/FULL) and CPU fetch port.
// Build option PROG_MEM_BYPASS_EN selects write-first read forwarding in prog_mem_ram.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_end,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic [ADDR_W:0]   words_loaded,
  output logic              overflow,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);
  localparam int BYTES = DATA_W / LANE_W;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  prog_mem_state_t   r_state, w_next_state;
  logic [CNT_W-1:0]  r_byte_cnt;
  logic [DATA_W-1:0] r_asm;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_words_loaded;
  logic              r_overflow;

  logic              w_xfer;
  logic              w_lane_last;
  logic              w_ptr_last;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_word;

  assign w_xfer      = in_valid & in_ready;
  assign w_lane_last = (r_byte_cnt == CNT_W'(BYTES - 1));
  assign w_ptr_last  = (r_ptr == ADDR_W'(DEPTH - 1));

  // Unfilled upper lanes stay zero because r_asm is cleared after every word.
  always_comb begin
    w_word = r_asm;
    if (w_xfer) w_word[{r_byte_cnt, 3'b000} +: LANE_W] = in_data;
  end

  // A restart discards whatever is in flight, so load_start suppresses the write.
  assign w_wr_en = (r_state == LOAD) && !load_start &&
                   ((w_xfer && w_lane_last) || (load_end && ((r_byte_cnt != '0) || w_xfer)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (load_start) w_next_state = LOAD;
      LOAD: begin
        if (load_start)                  w_next_state = LOAD;
        else if (load_end)               w_next_state = IDLE;
        else if (w_wr_en && w_ptr_last)  w_next_state = FULL;
      end
      FULL: begin
        if (load_start)    w_next_state = LOAD;
        else if (load_end) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != IDLE);
    in_ready = (r_state == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt     <= '0;
      r_asm          <= '0;
      r_ptr          <= '0;
      r_words_loaded <= '0;
      r_overflow     <= 1'b0;
    end else if (load_start) begin
      r_byte_cnt     <= '0;
      r_asm          <= '0;
      r_ptr          <= '0;
      r_words_loaded <= '0;
      r_overflow     <= 1'b0;
    end else begin
      if (r_state == LOAD) begin
        if (w_xfer && !w_lane_last && !load_end) begin
          r_byte_cnt <= r_byte_cnt + CNT_W'(1);
          r_asm      <= w_word;
        end else if (w_xfer || load_end) begin
          r_byte_cnt <= '0;
          r_asm      <= '0;
        end
        if (w_wr_en) begin
          r_words_loaded <= r_words_loaded + (ADDR_W+1)'(1);
          if (!w_ptr_last) r_ptr <= r_ptr + ADDR_W'(1);
        end
      end
      if ((r_state == FULL) && in_valid) r_overflow <= 1'b1;
    end
  end

  assign words_loaded = r_words_loaded;
  assign overflow     = r_overflow;

  prog_mem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (w_wr_en),
    .wr_addr  (r_ptr),
    .wr_data  (w_word),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );
endmodule
